mesh_shearsort_sequencer: RTL

Phase/step controller that drives the 16-PE mesh sorter through a shearsort schedule on a SIDE x SIDE grid. It alternates snake row-sort phases and column-sort phases; each phase is SIDE odd-even transposition steps. Each step is issued to the mesh as a one-cycle go pulse, and the mesh acknowledges it with a done pulse. The sequencer sits beside the mesh, is started by the application init logic, and flags completion so nanci_result can be sampled.

---
 rtl/mesh_shearsort_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mesh_shearsort_sequencer.sv
// Shearsort step sequencer: walks alternating snake-row and column phases of
// odd-even transposition steps, issuing one go pulse per step and awaiting the mesh ack.
module mesh_shearsort_sequencer #(
  parameter int N            = 16,
  parameter int SIDE         = 4,
  parameter int LOG_SIDE     = 2,
  parameter int STEP_TIMEOUT = 8,
  localparam int NUM_PHASES  = 2*LOG_SIDE + 1,
  localparam int PHASE_W     = $clog2(NUM_PHASES),
  localparam int STEP_W      = LOG_SIDE,
  localparam int CNT_W       = $clog2(NUM_PHASES*SIDE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               step_done,
  output logic               step_go,
  output logic               phase_row,
  output logic               step_parity,
  output logic [PHASE_W-1:0] phase_idx,
  output logic [STEP_W-1:0]  step_idx,
  output logic               busy,
  output logic               sort_done,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   steps_completed,
  output logic [2:0]         dbg_state
);

  localparam int TMR_W = $clog2(STEP_TIMEOUT);

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SIDE - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(STEP_TIMEOUT - 1);

  if (N != SIDE*SIDE || (1 << LOG_SIDE) != SIDE || SIDE < 2 || STEP_TIMEOUT < 2) begin : g_bad_params
    $error("mesh_shearsort_sequencer: inconsistent N/SIDE/LOG_SIDE/STEP_TIMEOUT");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0]    step_q,  step_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [TMR_W-1:0]     tmr_q,   tmr_d;
  logic                 err_q,   err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  // Abort freezes every counter and the error flag; only the state returns to IDLE.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ISSUE;
            phase_d = '0;
            step_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end
        S_WAIT: begin
          // An ack on the last permitted cycle still wins over the timeout.
          if (step_done) begin
            cnt_d = cnt_q + 1'b1;
            if (phase_q == PHASE_LAST && step_q == STEP_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              if (step_q == STEP_LAST) begin
                step_d  = '0;
                phase_d = phase_q + 1'b1;
              end else begin
                step_d = step_q + 1'b1;
              end
            end
          end else if (tmr_q == TMR_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Row/parity are only meaningful while a step is in flight, so they read 0 otherwise.
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign step_go         = (state_q == S_ISSUE);
  assign sort_done       = (state_q == S_DONE);
  assign phase_row       = busy & ~phase_q[0];
  assign step_parity     = busy & step_q[0];
  assign phase_idx       = phase_q;
  assign step_idx        = step_q;
  assign steps_completed = cnt_q;
  assign timeout_err     = err_q;
  assign dbg_state       = state_q;

endmodule
